uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver; the receive-side counterpart of the team's uart_transmitter.
- Frame format: 8N1, LSB first, idle-high line; one start bit (0), 8 data bits, one stop bit (1).
- Oversamples the asynchronous rx line with the system clock, samples each bit at mid-bit, and presents the byte with a one-cycle done strobe.
- Sits at the chip's serial input pin, in front of any command/FIFO logic.

Parameters:
- CLKS_PER_BIT, 868, system clocks per bit period (100 MHz / 115200 baud); legal range >= 4.
- CNT_W, $clog2(CLKS_PER_BIT), width of the bit-period counter (derived; do not override).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data_bit  input  1  asynchronous serial line; idles high.
- data  output  8  last received byte; held until the next completed frame.
- done  output  1  one-cycle strobe: data holds a valid new byte.
- frame_err  output  1  one-cycle strobe: the stop bit was sampled as 0.
- parity_err  output  1  one-cycle strobe for a parity mismatch; tied 0 unless UART_RX_PARITY_EN.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset:
  - data=0, done=0, frame_err=0, parity_err=0, busy=0.
  - FSM=IDLE, counters=0, synchronizer flops=1.
  - rst asserted mid-frame aborts the frame immediately. No strobe is issued and data is not updated.
- Input synchronization: data_bit passes through a 2-flop synchronizer (rx_s). All FSM decisions use rx_s, which adds 2 cycles of latency.
- FSM states: IDLE, START, DATA, [PARITY], STOP, WAIT_IDLE.
- IDLE:
  - rx_s==0 -> START, with clk_cnt cleared.
  - rx_s==1 -> stay in IDLE.
- START:
  - Count to CLKS_PER_BIT/2-1 (integer divide), then recheck rx_s.
  - rx_s==0 -> DATA, with clk_cnt=0 and bit_idx=0.
  - rx_s==1 -> false start; return to IDLE with no strobe.
- DATA:
  - Every CLKS_PER_BIT cycles, shift rx_s into shift_reg[bit_idx], LSB first.
  - After bit_idx==7 is sampled -> PARITY if enabled, otherwise STOP.
  - bit_idx wraps to 0.
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - rx_s==1: data<=shift_reg and done=1 for exactly one cycle; next state IDLE.
  - rx_s==0: frame_err=1 for one cycle, data unchanged, no done; next state WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1, then go to IDLE. This prevents a break condition from retriggering frames.
- Sampling points: bit k is sampled (k+1.5)*CLKS_PER_BIT cycles after the start edge reaches rx_s, with ±1 cycle integer-division tolerance.
- done latency: asserted about 9.5*CLKS_PER_BIT + 3 cycles after the data_bit falling edge.
- Back-to-back frames: a start bit arriving immediately after a valid stop sample is accepted. IDLE is reached before the line could have dropped.
- done and frame_err are never high in the same cycle.
- All arithmetic is unsigned. clk_cnt compares against CLKS_PER_BIT-1 and resets to 0; it never wraps past that value.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state between DATA and STOP samples the even-parity bit after one CLKS_PER_BIT period.
  - A mismatch against ^shift_reg sets a flag. At the STOP sample, parity_err=1 for one cycle instead of done.
  - data is not updated on a parity mismatch.
  - If the stop bit is also 0, frame_err takes priority and parity_err stays 0.
- Undefined: no PARITY state; parity_err is constant 0; frame length is 10 bits.

Decomposition:
- Package uart_pkg:
  - state enum encoding (IDLE..WAIT_IDLE), UART_DATA_W=8, STOP_BIT_VAL=1'b1.
  - Shared by the transmitter and receiver.
- Sub-module uart_rx_sync: parameterized 2-flop synchronizer with reset value 1. It is also reusable for other async inputs.
- The FSM, counters and shift register remain in uart_receiver.

Test Plan (CLKS_PER_BIT=16 for sim speed, clk period 10 ns):
- Send 0xAA as a valid 8N1 frame -> one done pulse, data==8'hAA, frame_err==0, busy low after STOP.
- Send 0x00 then 0xFF back-to-back with no idle gap -> two done pulses, with data 0x00 then 0xFF.
- Drive data_bit low for 4 clocks, then high -> no done, no frame_err, busy returns to 0 within 8 clocks.
- Send 0x55 with stop bit driven 0, then hold the line low for 40 clocks -> frame_err pulse, no done, data unchanged, no new frame until the line returns high.
- Assert rst for 1 cycle mid-frame during bit 4 of 0x3C, then send 0xC3 -> all outputs 0 after reset, next done with data==8'hC3.
- With UART_RX_PARITY_EN, send 0x0F with parity bit 1 (wrong) -> parity_err pulse, no done; resend with parity 0 -> done, data==8'h0F.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and line levels.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_state_t;

  localparam int unsigned UART_DATA_W  = 8;
  localparam logic        STOP_BIT_VAL = 1'b1;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Parameterized 2-flop synchronizer for asynchronous inputs; resets to RESET_VAL
// so an idle-high line does not look like activity coming out of reset.
module uart_rx_sync #(
  parameter int unsigned            WIDTH     = 1,
  parameter logic [WIDTH-1:0]       RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta     <= RESET_VAL;
      sync_out <= RESET_VAL;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first, mid-bit sampling of a synchronized rx line.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   data_bit,
  output logic [UART_DATA_W-1:0] data,
  output logic                   done,
  output logic                   frame_err,
  output logic                   parity_err,
  output logic                   busy
);

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam int unsigned      IDX_W    = $clog2(UART_DATA_W);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(UART_DATA_W - 1);

  logic                   rx_s;
  uart_state_t            state;
  uart_state_t            next_state;
  logic [CNT_W-1:0]       clk_cnt;
  logic [IDX_W-1:0]       bit_idx;
  logic [UART_DATA_W-1:0] shift_reg;
  logic                   cnt_tick;
  logic                   frame_ok;
  logic                   frame_bad;
  logic                   frame_good;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad;
  logic                   parity_fail;
`endif

  uart_rx_sync #(
    .WIDTH    (1),
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk     (clk),
    .rst     (rst),
    .async_in(data_bit),
    .sync_out(rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // START waits half a bit so every later tick lands in the middle of a bit.
  always_comb begin
    cnt_tick   = (state == ST_START) ? (clk_cnt == HALF_CNT) : (clk_cnt == LAST_CNT);
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (!rx_s) next_state = ST_START;
      end
      ST_START: begin
        if (cnt_tick) next_state = rx_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (cnt_tick && (bit_idx == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
          next_state = ST_PARITY;
`else
          next_state = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_tick) next_state = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (cnt_tick) next_state = (rx_s == STOP_BIT_VAL) ? ST_IDLE : ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (rx_s) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != ST_IDLE);
    frame_ok   = (state == ST_STOP) && cnt_tick && (rx_s == STOP_BIT_VAL);
    frame_bad  = (state == ST_STOP) && cnt_tick && (rx_s != STOP_BIT_VAL);
    frame_good = frame_ok;
`ifdef UART_RX_PARITY_EN
    // A bad stop bit wins: parity is only reported on an otherwise valid frame.
    frame_good  = frame_ok && !par_bad;
    parity_fail = frame_ok && par_bad;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      data      <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      done      <= frame_good;
      frame_err <= frame_bad;

      if ((state == ST_IDLE) || (state == ST_WAIT_IDLE) || cnt_tick) clk_cnt <= '0;
      else                                                             clk_cnt <= clk_cnt + CNT_W'(1);

      if (state == ST_START) begin
        bit_idx <= '0;
      end else if ((state == ST_DATA) && cnt_tick) begin
        shift_reg[bit_idx] <= rx_s;
        bit_idx            <= (bit_idx == LAST_BIT) ? '0 : bit_idx + IDX_W'(1);
      end

      if (frame_good) data <= shift_reg;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= parity_fail;
      if (state == ST_START)
        par_bad <= 1'b0;
      else if ((state == ST_PARITY) && cnt_tick)
        par_bad <= (rx_s != even_parity(shift_reg));
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frames plus randomized frames
// checked against a frame-level outcome model. Honors UART_RX_PARITY_EN.
module tb_uart_receiver;

  localparam int unsigned CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif
  localparam int FRAME_BITS = PARITY_EN ? 11 : 10;
  localparam int LAT_EXP    = (2 * FRAME_BITS - 1) * CPB / 2 + 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_bit;
  logic [7:0] data;
  logic       done;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int         checks   = 0;
  int         failures = 0;
  int         n_done, n_ferr, n_perr, n_both;
  logic [7:0] done_q[$];
  int         cyc = 0;
  int         done_cyc;
  int         start_cyc;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_bit  (data_bit),
    .data      (data),
    .done      (done),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Event monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (done) begin
      n_done++;
      done_q.push_back(data);
      done_cyc = cyc;
    end
    if (frame_err)          n_ferr++;
    if (parity_err)         n_perr++;
    if (done && frame_err)  n_both++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_events();
    n_done = 0;
    n_ferr = 0;
    n_perr = 0;
    done_q.delete();
  endtask

  task automatic drive_bit(input logic b);
    data_bit = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    data_bit = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PARITY_EN) drive_bit(par_v);
    drive_bit(stop_v);
    data_bit = 1'b1;
  endtask

  logic [7:0] b;
  logic [7:0] exp_data;
  logic       bad_stop, bad_par, exp_done;
  int         waited;

  initial begin
    n_both   = 0;
    rst      = 1'b1;
    data_bit = 1'b1;
    clear_events();
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_data", data, 8'h00);
    check("rst_done", done, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_perr", parity_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    idle(4);

    // Single valid frame plus done latency
    clear_events();
    send_frame(8'hAA, 1'b1, ^8'hAA);
    idle(4);
    check("aa_ndone", n_done, 1);
    check("aa_byte", (done_q.size() > 0) ? done_q[0] : 8'hxx, 8'hAA);
    check("aa_data", data, 8'hAA);
    check("aa_ferr", n_ferr, 0);
    check("aa_busy", busy, 1'b0);
    check("aa_lat_ok", ((done_cyc - start_cyc) >= LAT_EXP - 2) && ((done_cyc - start_cyc) <= LAT_EXP + 2), 1);

    // Back-to-back frames, no idle gap
    clear_events();
    send_frame(8'h00, 1'b1, ^8'h00);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    idle(4);
    check("b2b_ndone", n_done, 2);
    check("b2b_first", (done_q.size() > 0) ? done_q[0] : 8'hxx, 8'h00);
    check("b2b_second", (done_q.size() > 1) ? done_q[1] : 8'hxx, 8'hFF);
    check("b2b_data", data, 8'hFF);

    // False start: 4-clock glitch
    clear_events();
    data_bit = 1'b0;
    repeat (4) @(posedge clk);
    #1 data_bit = 1'b1;
    waited = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      waited++;
      if (!busy) break;
    end
    check("glitch_busy_low", busy, 1'b0);
    idle(2 * CPB);
    check("glitch_ndone", n_done, 0);
    check("glitch_ferr", n_ferr, 0);

    // Bad stop bit followed by a held-low break
    clear_events();
    send_frame(8'h55, 1'b0, ^8'h55);
    data_bit = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("brk_ferr", n_ferr, 1);
    check("brk_ndone", n_done, 0);
    check("brk_busy_held", busy, 1'b1);
    check("brk_data", data, 8'hFF);
    idle(3 * CPB);
    check("brk_busy_rel", busy, 1'b0);
    check("brk_ndone_after", n_done, 0);
    check("brk_ferr_after", n_ferr, 1);

    // Reset during bit 4 of 0x3C, then a clean 0xC3
    clear_events();
    b = 8'h3C;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    data_bit = b[4];
    repeat (CPB / 2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mrst_data", data, 8'h00);
    check("mrst_done", done, 1'b0);
    check("mrst_ferr", frame_err, 1'b0);
    check("mrst_busy", busy, 1'b0);
    idle(2 * CPB);
    check("mrst_ndone", n_done, 0);
    send_frame(8'hC3, 1'b1, ^8'hC3);
    idle(4);
    check("mrst_c3_ndone", n_done, 1);
    check("mrst_c3_data", data, 8'hC3);
    exp_data = 8'hC3;

`ifdef UART_RX_PARITY_EN
    clear_events();
    send_frame(8'h0F, 1'b1, 1'b1);
    idle(4);
    check("par_bad_perr", n_perr, 1);
    check("par_bad_ndone", n_done, 0);
    check("par_bad_data", data, 8'hC3);
    clear_events();
    send_frame(8'h0F, 1'b1, 1'b0);
    idle(4);
    check("par_ok_perr", n_perr, 0);
    check("par_ok_ndone", n_done, 1);
    check("par_ok_data", data, 8'h0F);
    exp_data = 8'h0F;
`endif

    // Randomized frames against the frame-outcome model
    for (int f = 0; f < 24; f++) begin
      b        = 8'($urandom_range(0, 255));
      bad_stop = ($urandom_range(0, 4) == 0);
      bad_par  = PARITY_EN && ($urandom_range(0, 3) == 0);
      exp_done = !bad_stop && !bad_par;
      clear_events();
      send_frame(b, !bad_stop, (^b) ^ bad_par);
      if (exp_done) exp_data = b;
      check("rnd_ndone", n_done, {31'd0, exp_done});
      check("rnd_ferr", n_ferr, {31'd0, bad_stop});
      check("rnd_perr", n_perr, {31'd0, !bad_stop && bad_par});
      check("rnd_data", data, exp_data);
      if (bad_stop) idle($urandom_range(2, 2 * CPB));
      else          idle($urandom_range(0, 2 * CPB));
    end

    idle(2 * CPB);
    check("done_ferr_overlap", n_both, 0);
    check("final_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
